// File: rtl/usb_tx_pkg.sv
// ---------------------------------------------------------------------------
// usb_tx_pkg
// Shared definitions for the USB transmit path (bit stuffer, NRZI encoder).
//   tx_state_e    : bit stuffer sequencing states
//   USB_STUFF_LEN : run of consecutive data 1s that forces a stuff 0
// ---------------------------------------------------------------------------
package usb_tx_pkg;

  localparam int USB_STUFF_LEN = 6;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_e;

endpackage

// File: rtl/usb_bit_stuffer.sv
// ---------------------------------------------------------------------------
// usb_bit_stuffer
// Serializes bytes LSB-first and inserts a 0 after every STUFF_LEN
// consecutive data 1s. Feeds the NRZI encoder (bit_out -> curr_bit,
// bit_valid -> start_encoding). One bit slot per bit_en strobe.
//
// Ports
//   clk, rst     : clock, asynchronous active-high reset
//   bit_en       : bit-rate strobe, one bit slot per high cycle
//   byte_in      : byte to send (LSB first)
//   byte_valid   : byte_in / byte_last valid
//   byte_last    : final byte of the packet
//   byte_ready   : holding register empty (combinational decode of a flop)
//   bit_out      : serial bit
//   bit_valid    : a packet bit is on bit_out
//   stuff_flag   : bit_out is an inserted stuff bit
//   underrun     : one-clock pulse when a slot found no data mid-packet
// ---------------------------------------------------------------------------
module usb_bit_stuffer
  import usb_tx_pkg::*;
#(
  parameter int STUFF_LEN = USB_STUFF_LEN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_en,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  input  logic       byte_last,
  output logic       byte_ready,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       stuff_flag,
  output logic       underrun
);

  localparam int                CNT_W     = $clog2(STUFF_LEN + 1);
  localparam logic [CNT_W-1:0]  STUFF_CNT = CNT_W'(STUFF_LEN);

  tx_state_e        state;
  logic [7:0]       hold_data;
  logic             hold_last;
  logic             hold_full;
  logic [7:0]       shift_reg;
  logic             shift_last;
  logic [2:0]       bit_idx;
  logic [CNT_W-1:0] ones_cnt;
  logic [2:0]       nxt_idx;

  assign byte_ready = !hold_full;
  assign nxt_idx    = bit_idx + 3'd1;

  // Ones run after emitting data bit b: a 1 extends the run, a 0 breaks it.
  function automatic logic [CNT_W-1:0] next_ones(input logic b,
                                                 input logic [CNT_W-1:0] cnt);
    return b ? cnt + CNT_W'(1) : '0;
  endfunction

  // NOTE: all state here uses non-blocking assignments so every flop samples
  // the pre-edge values of the others; blocking would make the ones counter
  // and the shift index see this edge's updates and skew the bit stream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the data registers are reset along with the control flags so a
      // packet cut short by reset leaves nothing behind to be resent.
      state      <= IDLE;
      hold_data  <= '0;
      hold_last  <= 1'b0;
      hold_full  <= 1'b0;
      shift_reg  <= '0;
      shift_last <= 1'b0;
      bit_idx    <= '0;
      ones_cnt   <= '0;
      bit_out    <= 1'b0;
      bit_valid  <= 1'b0;
      stuff_flag <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      underrun <= 1'b0;

      // Capture is independent of bit_en. It can never coincide with a load
      // because a load needs hold_full=1 and capture needs hold_full=0.
      if (byte_valid && byte_ready) begin
        hold_data <= byte_in;
        hold_last <= byte_last;
        hold_full <= 1'b1;
      end

      if (bit_en) begin
        case (state)
          IDLE: begin
            if (hold_full) begin
              state      <= SEND;
              shift_reg  <= hold_data;
              shift_last <= hold_last;
              hold_full  <= 1'b0;
              bit_idx    <= '0;
              bit_out    <= hold_data[0];
              bit_valid  <= 1'b1;
              stuff_flag <= 1'b0;
              ones_cnt   <= next_ones(hold_data[0], '0);
            end
          end

          SEND: begin
            if (ones_cnt == STUFF_CNT) begin
              // Stuff has priority even after the final data bit, so a run
              // ending the packet is still closed before bit_valid drops.
              bit_out    <= 1'b0;
              stuff_flag <= 1'b1;
              ones_cnt   <= '0;
            end else if (bit_idx != 3'd7) begin
              bit_idx    <= nxt_idx;
              bit_out    <= shift_reg[nxt_idx];
              stuff_flag <= 1'b0;
              ones_cnt   <= next_ones(shift_reg[nxt_idx], ones_cnt);
            end else if (shift_last) begin
              state      <= IDLE;
              shift_last <= 1'b0;
              bit_out    <= 1'b0;
              bit_valid  <= 1'b0;
              stuff_flag <= 1'b0;
              ones_cnt   <= '0;
            end else if (hold_full) begin
              // Back-to-back byte: the ones run carries across the boundary.
              shift_reg  <= hold_data;
              shift_last <= hold_last;
              hold_full  <= 1'b0;
              bit_idx    <= '0;
              bit_out    <= hold_data[0];
              stuff_flag <= 1'b0;
              ones_cnt   <= next_ones(hold_data[0], ones_cnt);
            end else begin
              state      <= IDLE;
              shift_last <= 1'b0;
              bit_out    <= 1'b0;
              bit_valid  <= 1'b0;
              stuff_flag <= 1'b0;
              ones_cnt   <= '0;
              underrun   <= 1'b1;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_bit_stuffer.sv
// ---------------------------------------------------------------------------
// tb_usb_bit_stuffer
// Directed packets with hand-derived serial streams. The stimulus side pushes
// the expected slots into a queue; a monitor pops one entry per bit slot in
// which bit_valid is high or has just fallen. Between slots the monitor
// requires the serial outputs to hold still and underrun to stay low.
//
// Stream encoding: '0'/'1' data bit, 'S' stuff 0, 'E' packet end (bit_valid
// falls), 'U' underrun end (bit_valid falls with an underrun pulse).
// ---------------------------------------------------------------------------
module tb_usb_bit_stuffer;
  import usb_tx_pkg::*;

  typedef struct packed {
    logic valid;
    logic b;
    logic stuff;
    logic und;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       bit_en;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_last;
  logic       byte_ready;
  logic       bit_out;
  logic       bit_valid;
  logic       stuff_flag;
  logic       underrun;

  usb_bit_stuffer #(.STUFF_LEN(USB_STUFF_LEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_en     (bit_en),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_last  (byte_last),
    .byte_ready (byte_ready),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .stuff_flag (stuff_flag),
    .underrun   (underrun)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  int   en_div = 1;
  logic en_seen = 1'b0;
  logic prev_out, prev_valid, prev_stuff;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // bit_en generator: every cycle when en_div==1, else one cycle in en_div.
  initial begin
    int cnt;
    cnt    = 0;
    bit_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (en_div <= 1) begin
        bit_en = 1'b1;
      end else begin
        if (cnt >= en_div) cnt = 0;
        bit_en = (cnt == 0);
        cnt++;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    en_seen = bit_en;
  end

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_seq(input string s);
    exp_t e;
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        "0":     e = '{valid: 1'b1, b: 1'b0, stuff: 1'b0, und: 1'b0};
        "1":     e = '{valid: 1'b1, b: 1'b1, stuff: 1'b0, und: 1'b0};
        "S":     e = '{valid: 1'b1, b: 1'b0, stuff: 1'b1, und: 1'b0};
        "E":     e = '{valid: 1'b0, b: 1'b0, stuff: 1'b0, und: 1'b0};
        default: e = '{valid: 1'b0, b: 1'b0, stuff: 1'b0, und: 1'b1};
      endcase
      exp_q.push_back(e);
    end
  endtask

  // Monitor: one comparison set per active slot, stability checks otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (en_seen) begin
        if (bit_valid || prev_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_slot", {7'd0, bit_valid}, 8'd0);
          end else begin
            e = exp_q.pop_front();
            check("bit_valid", {7'd0, bit_valid}, {7'd0, e.valid});
            if (e.valid) check("bit_out", {7'd0, bit_out}, {7'd0, e.b});
            check("stuff_flag", {7'd0, stuff_flag}, {7'd0, e.stuff});
            check("underrun", {7'd0, underrun}, {7'd0, e.und});
          end
        end else begin
          check("idle_underrun", {7'd0, underrun}, 8'd0);
        end
      end else begin
        check("hold_bit_out", {7'd0, bit_out}, {7'd0, prev_out});
        check("hold_bit_valid", {7'd0, bit_valid}, {7'd0, prev_valid});
        check("hold_stuff_flag", {7'd0, stuff_flag}, {7'd0, prev_stuff});
        check("hold_underrun", {7'd0, underrun}, 8'd0);
      end
    end
    prev_out   = bit_out;
    prev_valid = bit_valid;
    prev_stuff = stuff_flag;
  end

  task automatic send_byte(input logic [7:0] data, input logic last);
    logic rdy;
    int   n;
    @(posedge clk);
    #1;
    byte_in    = data;
    byte_last  = last;
    byte_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      rdy = byte_ready;
      @(posedge clk);
      n++;
    end while (!rdy && n < 2000);
    if (!rdy) check("accept_timeout", 8'd0, 8'd1);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check({name, "_drain_timeout"}, exp_q.size() > 255 ? 8'hff : 8'(exp_q.size()), 8'd0);
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_bit_out"}, {7'd0, bit_out}, 8'd0);
    check({name, "_bit_valid"}, {7'd0, bit_valid}, 8'd0);
    check({name, "_stuff_flag"}, {7'd0, stuff_flag}, 8'd0);
    check({name, "_underrun"}, {7'd0, underrun}, 8'd0);
    check({name, "_byte_ready"}, {7'd0, byte_ready}, 8'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    byte_in    = '0;
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_reset");

    // 0xFF then 0x00(last): stuff after six 1s, run continues into next byte.
    push_seq("111111S1100000000E");
    send_byte(8'hFF, 1'b0);
    send_byte(8'h00, 1'b1);
    wait_drain("ff_00");

    // 0x7E last: 0,1x6, stuff, 0.
    push_seq("0111111S0E");
    send_byte(8'h7E, 1'b1);
    wait_drain("7e");

    // 0xFC last: run ends on final data bit, stuff still precedes the end.
    push_seq("00111111SE");
    send_byte(8'hFC, 1'b1);
    wait_drain("fc");

    // 0xA5 not last, no follow-on byte: underrun, then a fresh 0x01 packet.
    push_seq("10100101U");
    send_byte(8'hA5, 1'b0);
    wait_drain("a5");
    repeat (3) @(posedge clk);
    push_seq("10000000E");
    send_byte(8'h01, 1'b1);
    wait_drain("01");

    // Reset mid-packet with bit_en every 4th cycle: 0x3C in flight, 0x81 held.
    en_div = 4;
    push_seq("0011");
    send_byte(8'h3C, 1'b0);
    send_byte(8'h81, 1'b0);
    wait_drain("3c");
    check("pre_rst_byte_ready", {7'd0, byte_ready}, 8'd0);
    check("pre_rst_bit_out", {7'd0, bit_out}, 8'd1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_rst_release");

    // 0xFF last: exactly six 1s before the stuff, so no ones survived reset.
    push_seq("111111S11E");
    send_byte(8'hFF, 1'b1);
    wait_drain("ff_after_rst");

    repeat (10) @(posedge clk);
    check("queue_empty", exp_q.size() > 255 ? 8'hff : 8'(exp_q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usb_bit_stuffer.md
# usb_bit_stuffer

Transmit-path stage that serializes bytes LSB-first and inserts a 0 bit after every six consecutive 1 bits, as USB bit stuffing requires. It sits directly upstream of the NRZI encoder: `bit_out` drives the encoder's `curr_bit`, and `bit_valid` drives its `start_encoding`. Bytes arrive through a valid/ready handshake from the packet assembler. Bit timing comes from an external bit-rate strobe.

## Interface
- `STUFF_LEN`, default 6: number of consecutive data 1s that triggers insertion of a stuff 0.
- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous, active-high reset.
- `bit_en`  in  1: bit-rate strobe; each high cycle is one bit slot.
- `byte_in`  in  8: byte to transmit, sent LSB first.
- `byte_valid`  in  1: `byte_in` and `byte_last` are valid.
- `byte_last`  in  1: this byte is the final byte of the packet.
- `byte_ready`  out  1: the holding register can accept a byte.
- `bit_out`  out  1: current serial bit, to NRZI `curr_bit`.
- `bit_valid`  out  1: a packet bit is on `bit_out`, to NRZI `start_encoding`.
- `stuff_flag`  out  1: high while `bit_out` is an inserted stuff bit.
- `underrun`  out  1: one-cycle pulse when a bit slot finds no data mid-packet.

## Operation
- Storage: one 8-bit holding register plus its `last` flag and `full` flag; an 8-bit shift register with its `last` flag; a 3-bit bit index; a ones counter wide enough for `STUFF_LEN`.
- Handshake:
  - `byte_ready = !hold_full`.
  - A transfer occurs on an edge where `byte_valid && byte_ready`.
  - `byte_in` and `byte_last` are captured into the holding register.
- States:
  - IDLE: `bit_valid=0`. On `bit_en` with `hold_full`, load the shift register from the holding register, drive bit 0 on `bit_out`, and go to SEND.
  - SEND: on `bit_en`, the slot is decided in this priority:
    1. If ones_cnt == `STUFF_LEN`, emit a stuff 0, clear ones_cnt, set `stuff_flag`, and stay in SEND.
    2. Otherwise, if the current byte has remaining bits, emit the next bit.
    3. Otherwise, if the byte was last, go to DONE behaviour: drop `bit_valid` and return to IDLE.
    4. Otherwise, if `hold_full`, load the next byte and emit its bit 0.
    5. Otherwise, pulse `underrun`, drop `bit_valid`, clear the packet state, and go to IDLE.
- Ones counter:
  - Increments when a data 1 is emitted.
  - Clears when a data 0 is emitted, a stuff bit is emitted, or the block leaves SEND.
  - It does not carry across packets.
- End of packet: if the final data bit leaves ones_cnt == `STUFF_LEN`, the stuff 0 is still emitted before `bit_valid` drops.
- Holding-register refill: loading the shift register from the holding register clears `hold_full` on the same edge. A new byte may be accepted on the following edge, which allows streaming with no gaps.
- Cycles with `bit_en`=0 leave all outputs and state unchanged, except for the handshake capture.

## Timing
- Reset values:
  - `bit_out`=0, `bit_valid`=0, `stuff_flag`=0, `underrun`=0, `byte_ready`=1.
  - State IDLE, ones_cnt=0, both registers empty.
- All outputs are registered except `byte_ready`, which is a direct decode of the `hold_full` flop.
- Latency: the first bit appears on the first `bit_en` edge strictly after the accept edge. A byte accepted on the same edge as a `bit_en` is not transmitted until the next `bit_en`.
- Once in SEND, each `bit_en` edge advances exactly one bit slot. `bit_out`, `bit_valid` and `stuff_flag` change only on `bit_en` edges. The exception is `rst`.
- `underrun` is high for exactly one clock.
- `rst` asserted mid-packet:
  - Outputs return to reset values asynchronously.
  - A partially sent byte and any held byte are discarded.
  - No stuff bit or completion is emitted.

## Structure
- Shared package `usb_tx_pkg` holds:
  - the state enum: IDLE, SEND;
  - `USB_STUFF_LEN = 6`, used as the default for `STUFF_LEN`.
- The NRZI encoder also imports `usb_tx_pkg` for any shared constants.
- Single module, no sub-module. The holding register is small enough to stay inline.

## Test plan
- Send 0xFF then 0x00 with `byte_last` on 0x00, and `bit_en` every cycle:
  - Required `bit_out`: 1,1,1,1,1,1,0(stuff),1,1,0,0,0,0,0,0,0,0. That is 17 slots, with `stuff_flag` high only on slot 7.
  - `bit_valid` drops on the following slot.
- Single byte 0x7E, last:
  - Required `bit_out`: 0,1,1,1,1,1,1,0(stuff),0, which is 9 slots.
- Single byte 0xFC, last:
  - Required `bit_out`: 0,0,1,1,1,1,1,1,0(stuff).
  - The stuff bit must appear before `bit_valid` falls.
- Send 0xA5 not-last, then withhold `byte_valid`:
  - Required: 8 data bits, then `underrun` pulses for 1 cycle.
  - `bit_valid`=0 and the block is back in IDLE.
  - A new 0x01 packet then starts with ones_cnt=0.
- Assert `rst` while bit 3 of 0x3C is out, with `bit_en` every 4th cycle:
  - Outputs go to reset values immediately and `byte_ready`=1.
  - The next packet, 0xFF last, sends 1×6, stuff 0, 1,1, with no leftover ones from before reset.
